mem_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one simple memory (sync write, combinational read) among
//   NUM_REQ requesters. Each requester has a valid/ready request channel and a response strobe.
//   The arbiter accepts at most one request per cycle: a write or a read.
//   It drives the memory's write port and read port, and registers read data back to the winner.
//   It sits between client engines and the mem instance; the mem instance is not inside this block.

---
 rtl/mem_rr_arbiter_if.sv | 73 +++++++
 rtl/mem_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter_if
//   Bundle of every non-clock signal of mem_rr_arbiter: the per-requester
//   request/response channels and the ports toward the shared memory.
//
//   Signals (directions seen from the arbiter):
//     req_valid_i  in   NUM_REQ              per-requester request valid
//     req_we_i     in   NUM_REQ              per-requester op: 1=write, 0=read
//     req_addr_i   in   NUM_REQ x ADDR_WIDTH per-requester address
//     req_wdata_i  in   NUM_REQ x DATA_WIDTH per-requester write data
//     req_ready_o  out  NUM_REQ              one-hot grant (handshake = valid & ready)
//     rsp_valid_o  out  NUM_REQ              one-cycle read-response strobe
//     rsp_rdata_o  out  DATA_WIDTH           shared read data, qualified by rsp_valid_o
//     mem_we_o     out  1                    memory write enable
//     mem_waddr_o  out  ADDR_WIDTH           memory write address
//     mem_wdata_o  out  DATA_WIDTH           memory write data
//     mem_raddr_o  out  ADDR_WIDTH           memory read address
//     mem_rdata_i  in   DATA_WIDTH           memory read data (combinational)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment around it (client engines plus the memory)
// -----------------------------------------------------------------------------
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0]                 req_we_i;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic [NUM_REQ-1:0]                 rsp_valid_o;
    logic [DATA_WIDTH-1:0]              rsp_rdata_o;
    logic                               mem_we_o;
    logic [ADDR_WIDTH-1:0]              mem_waddr_o;
    logic [DATA_WIDTH-1:0]              mem_wdata_o;
    logic [ADDR_WIDTH-1:0]              mem_raddr_o;
    logic [DATA_WIDTH-1:0]              mem_rdata_i;

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_rdata_o,
        output mem_we_o,
        output mem_waddr_o,
        output mem_wdata_o,
        output mem_raddr_o
    );

    modport master (
        output req_valid_i,
        output req_we_i,
        output req_addr_i,
        output req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_rdata_o,
        input  mem_we_o,
        input  mem_waddr_o,
        input  mem_wdata_o,
        input  mem_raddr_o
    );

endinterface

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
//   Round-robin arbiter sharing one memory (synchronous write, combinational
//   read) among NUM_REQ requesters. At most one request (read or write) is
//   accepted per cycle. Writes go straight to the memory write port in the
//   grant cycle; reads drive the memory read port and the returned data is
//   registered, so the response strobe appears exactly one cycle after the
//   handshake.
//
//   Ports:
//     clk_i   in  1   clock, rising edge
//     arst_i  in  1   asynchronous active-high reset (pointer and response
//                     registers only; memory contents are untouched)
//     bus     mem_rr_arbiter_if.slave - request/response channels and the
//                     memory write/read ports (see the interface header)
// -----------------------------------------------------------------------------
module mem_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                arst_i,
    mem_rr_arbiter_if.slave     bus
);

    localparam int               PTR_W    = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PTR_W-1:0]      r_prio_ptr;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    // ---------------------------------------------------------------------
    // Arbitration results
    // ---------------------------------------------------------------------
    int unsigned           w_scan_idx;
    logic                  w_found;
    logic [PTR_W-1:0]      w_win;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_wr_grant;
    logic                  w_rd_grant;

    // Memory-side and handshake outputs
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [ADDR_WIDTH-1:0] w_mem_raddr;

    // Scan requesters starting at the priority pointer, wrapping past the top
    // index; the first valid one found wins. The wrap is done with a compare
    // and subtract so NUM_REQ need not be a power of two.
    always_comb begin
        w_scan_idx = 0;
        w_found    = 1'b0;
        w_win      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = 32'(r_prio_ptr) + 32'(k);
            if (w_scan_idx >= 32'(NUM_REQ)) begin
                w_scan_idx = w_scan_idx - 32'(NUM_REQ);
            end
            if (!w_found && bus.req_valid_i[w_scan_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_scan_idx[PTR_W-1:0];
            end
        end
    end

    // The requester just served drops to lowest priority.
    always_comb begin
        if (w_win == LAST_IDX) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_win + PTR_W'(1);
        end
    end

    always_comb begin
        w_grant    = '0;
        w_wr_grant = 1'b0;
        w_rd_grant = 1'b0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
            w_wr_grant     = bus.req_we_i[w_win];
            w_rd_grant     = ~bus.req_we_i[w_win];
        end
    end

    // Memory ports are forced to zero unless the matching operation is
    // granted, so an idle or opposite-direction cycle never leaks a
    // requester's address or data onto the memory bus.
    always_comb begin
        w_mem_we    = w_wr_grant;
        w_mem_waddr = '0;
        w_mem_wdata = '0;
        w_mem_raddr = '0;
        if (w_wr_grant) begin
            w_mem_waddr = bus.req_addr_i[w_win];
            w_mem_wdata = bus.req_wdata_i[w_win];
        end
        if (w_rd_grant) begin
            w_mem_raddr = bus.req_addr_i[w_win];
        end
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_prio_ptr <= '0;
        end else if (w_found) begin
            r_prio_ptr <= w_ptr_next;
        end
    end

    // Read data is captured only on a read grant; it holds across idle and
    // write cycles so the last response stays visible on the shared bus.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd_grant ? w_grant : '0;
            if (w_rd_grant) begin
                r_rsp_rdata <= bus.mem_rdata_i;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output drive
    // ---------------------------------------------------------------------
    assign bus.req_ready_o = w_grant;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_waddr_o = w_mem_waddr;
    assign bus.mem_wdata_o = w_mem_wdata;
    assign bus.mem_raddr_o = w_mem_raddr;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
//   Self-checking bench for mem_rr_arbiter: a small memory stub on the memory
//   ports, a reference model of the arbitration/memory rules, a vector table,
//   hand-written corner sequences and a randomized phase.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus)
    );

    // Memory stub driven only by the DUT's memory ports.
    logic [DW-1:0] stub_mem [256];
    always @(posedge clk) begin
        if (bus.mem_we_o === 1'b1) stub_mem[bus.mem_waddr_o] = bus.mem_wdata_o;
    end
    assign bus.mem_rdata_i = stub_mem[bus.mem_raddr_o];

    // Reference model state.
    int            m_ptr;
    logic [N-1:0]  m_rsp_valid;
    logic [DW-1:0] m_rsp_rdata;
    logic [DW-1:0] ref_mem [256];

    int n_cmp = 0;
    int n_bad = 0;
    int last_win;

    logic [N-1:0]  cap_ready;
    logic          cap_we;
    logic [AW-1:0] cap_waddr;
    logic [AW-1:0] cap_raddr;
    logic [N-1:0]  cap_rsp_valid;
    logic [DW-1:0] cap_rsp_rdata;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  we;
        logic [N-1:0]  exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic [AW-1:0] exp_raddr;
        logic [N-1:0]  exp_rsp;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Winner = the valid requester at the smallest forward distance from ptr.
    function automatic int model_win(input logic [N-1:0] v, input int ptr);
        int best = N;
        int w    = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d = (i - ptr + N) % N;
                if (d < best) begin
                    best = d;
                    w    = i;
                end
            end
        end
        return w;
    endfunction

    task automatic clr();
        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid_i[i] = 1'b1;
        bus.req_we_i[i]    = we;
        bus.req_addr_i[i]  = a;
        bus.req_wdata_i[i] = d;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        int            w;
        logic [N-1:0]  e_ready;
        logic          e_we;
        logic [AW-1:0] e_waddr;
        logic [AW-1:0] e_raddr;
        logic [DW-1:0] e_wdata;
        w       = model_win(bus.req_valid_i, m_ptr);
        e_ready = '0;
        e_we    = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
        e_raddr = '0;
        if (w >= 0) begin
            e_ready[w] = 1'b1;
            if (bus.req_we_i[w]) begin
                e_we    = 1'b1;
                e_waddr = bus.req_addr_i[w];
                e_wdata = bus.req_wdata_i[w];
            end else begin
                e_raddr = bus.req_addr_i[w];
            end
        end
        #4;
        cap_ready = bus.req_ready_o;
        cap_we    = bus.mem_we_o;
        cap_waddr = bus.mem_waddr_o;
        cap_raddr = bus.mem_raddr_o;
        chk("ready",     64'(cap_ready),       64'(e_ready));
        chk("mem_we",    64'(cap_we),          64'(e_we));
        chk("mem_waddr", 64'(cap_waddr),       64'(e_waddr));
        chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(e_wdata));
        chk("mem_raddr", 64'(cap_raddr),       64'(e_raddr));
        @(posedge clk);
        m_rsp_valid = '0;
        if (w >= 0) begin
            if (e_we) begin
                ref_mem[e_waddr] = e_wdata;
            end else begin
                m_rsp_valid[w] = 1'b1;
                m_rsp_rdata    = ref_mem[e_raddr];
            end
            m_ptr = (w + 1) % N;
        end
        last_win = w;
        #1;
        cap_rsp_valid = bus.rsp_valid_o;
        cap_rsp_rdata = bus.rsp_rdata_o;
        chk("rsp_valid", 64'(cap_rsp_valid), 64'(m_rsp_valid));
        chk("rsp_rdata", 64'(cap_rsp_rdata), 64'(m_rsp_rdata));
    endtask

    // Called at posedge+1; returns at a later posedge+1 with reset released.
    task automatic do_reset();
        arst = 1'b1;
        #1;
        m_ptr       = 0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        clr();
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    bit            p_v  [N];
    bit            p_we [N];
    logic [AW-1:0] p_a  [N];
    logic [DW-1:0] p_d  [N];

    initial begin
        int load;
        for (int i = 0; i < 256; i++) begin
            stub_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        m_ptr       = 0;
        m_rsp_valid = '0;
        m_rsp_rdata = '0;
        arst        = 1'b1;
        clr();

        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 8'h00, 8'h20, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 8'h00, 8'h21, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 8'h00, 8'h22, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0, 8'h00, 8'h23, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0, 8'h00, 8'h20, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0, 8'h00, 8'h21, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0, 8'h00, 8'h22, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0, 8'h00, 8'h23, 4'b1000};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 1'b1, 8'h22, 8'h00, 4'b0000};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 4'b0000};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 4'b0000};
        tbl[12] = '{4'b1010, 4'b0000, 4'b1000, 1'b0, 8'h00, 8'h23, 4'b1000};
        tbl[13] = '{4'b0010, 4'b0000, 4'b0010, 1'b0, 8'h00, 8'h21, 4'b0010};
        tbl[14] = '{4'b0011, 4'b0001, 4'b0001, 1'b1, 8'h20, 8'h00, 4'b0000};
        tbl[15] = '{4'b0011, 4'b0001, 4'b0010, 1'b0, 8'h00, 8'h21, 4'b0010};

        // Power-on reset
        @(posedge clk);
        #1;
        arst = 1'b0;
        chk("por_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("por_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));

        // Reset in the middle of a read response
        clr(); set_req(0, 1'b1, 8'h33, 32'h1234_5678); cycle();
        clr(); set_req(0, 1'b0, 8'h33, 32'h0);         cycle();
        chk("t1_rsp_before_rst", 64'(cap_rsp_rdata), 64'(32'h1234_5678));
        #1;
        arst = 1'b1;
        #1;
        chk("t1_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("t1_rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));
        m_ptr = 0; m_rsp_valid = '0; m_rsp_rdata = '0;
        clr();
        @(posedge clk);
        #1;
        arst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'h40 + 8'(i), 32'h0);
        cycle();
        chk("t1_first_grant", 64'(cap_ready), 64'(4'b0001));

        // Vector table: fairness, pointer hold across idle, write/read mix
        do_reset();
        for (int r = 0; r < 16; r++) begin
            clr();
            for (int i = 0; i < N; i++) begin
                if (tbl[r].valid[i]) set_req(i, tbl[r].we[i], 8'h20 + 8'(i), 32'hA000_0000 + 32'(i));
            end
            cycle();
            chk($sformatf("tbl%0d_ready", r), 64'(cap_ready),     64'(tbl[r].exp_ready));
            chk($sformatf("tbl%0d_we", r),    64'(cap_we),        64'(tbl[r].exp_we));
            chk($sformatf("tbl%0d_waddr", r), 64'(cap_waddr),     64'(tbl[r].exp_waddr));
            chk($sformatf("tbl%0d_raddr", r), 64'(cap_raddr),     64'(tbl[r].exp_raddr));
            chk($sformatf("tbl%0d_rsp", r),   64'(cap_rsp_valid), 64'(tbl[r].exp_rsp));
        end

        // Single write then read from requester 1
        clr(); set_req(1, 1'b1, 8'h10, 32'hDEAD_BEEF); cycle();
        clr(); set_req(1, 1'b0, 8'h10, 32'h0);         cycle();
        chk("t2_rsp_valid", 64'(cap_rsp_valid), 64'(4'b0010));
        chk("t2_rsp_rdata", 64'(cap_rsp_rdata), 64'(32'hDEAD_BEEF));

        // Back-to-back from requester 0 alone
        clr(); set_req(0, 1'b1, 8'h05, 32'h1); cycle();
        chk("t5_ready_w1", 64'(cap_ready), 64'(4'b0001));
        clr(); set_req(0, 1'b0, 8'h05, 32'h0); cycle();
        chk("t5_ready_r1", 64'(cap_ready), 64'(4'b0001));
        chk("t5_rdata_1",  64'(cap_rsp_rdata), 64'(32'h1));
        chk("t5_rsp_1",    64'(cap_rsp_valid), 64'(4'b0001));
        clr(); set_req(0, 1'b1, 8'h05, 32'h2); cycle();
        chk("t5_ready_w2", 64'(cap_ready), 64'(4'b0001));
        clr(); set_req(0, 1'b0, 8'h05, 32'h0); cycle();
        chk("t5_ready_r2", 64'(cap_ready), 64'(4'b0001));
        chk("t5_rdata_2",  64'(cap_rsp_rdata), 64'(32'h2));

        // Pointer wrap from 3 to 0, top address round trip
        do_reset();
        clr(); set_req(2, 1'b0, 8'h00, 32'h0); cycle();
        clr(); set_req(3, 1'b1, 8'hFF, 32'hCAFE_F00D); cycle();
        chk("t6_grant3", 64'(cap_ready), 64'(4'b1000));
        clr(); set_req(0, 1'b0, 8'h01, 32'h0); set_req(3, 1'b0, 8'hFF, 32'h0); cycle();
        chk("t6_wrap_grant0", 64'(cap_ready), 64'(4'b0001));
        clr(); set_req(3, 1'b0, 8'hFF, 32'h0); cycle();
        chk("t6_rsp3",   64'(cap_rsp_valid), 64'(4'b1000));
        chk("t6_rdataFF", 64'(cap_rsp_rdata), 64'(32'hCAFE_F00D));

        // Randomized traffic against the model; requests held until granted
        for (int i = 0; i < N; i++) p_v[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            load = (c < 1000) ? 30 : (c < 2000) ? 95 : 60;
            if (c % 700 == 699) do_reset();
            for (int i = 0; i < N; i++) begin
                if (!p_v[i] && $urandom_range(0, 99) < load) begin
                    p_v[i]  = 1'b1;
                    p_we[i] = 1'($urandom_range(0, 1));
                    p_a[i]  = 8'($urandom_range(0, 15));
                    p_d[i]  = $urandom;
                end
            end
            clr();
            for (int i = 0; i < N; i++) begin
                if (p_v[i]) set_req(i, p_we[i], p_a[i], p_d[i]);
            end
            cycle();
            if (last_win >= 0) p_v[last_win] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
